fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
Parametrised single-clock FIFO with on-board storage, occupancy counter, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-clock successor to the team's dual-clock FIFO controller, for buffering within one clock domain. Pointers use binary plus a wrap bit, so no Gray conversion or synchronisers are needed. A synchronous flush input empties the FIFO without a reset.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (default 16)
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush; empties FIFO and clears error flags
w_en  input  1  write request
w_data  input  DATA_W  write data
r_en  input  1  read request
r_data  output  DATA_W  read data, registered
r_valid  output  1  r_data holds a freshly read word (1-cycle pulse)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
w_ptr  output  ADDR_W+1  write pointer, binary with wrap MSB
r_ptr  output  ADDR_W+1  read pointer, binary with wrap MSB

Behaviour:
- Reset (rst=1, asynchronous) and clr (synchronous) both set: w_ptr=0, r_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, r_valid=0. rst also sets r_data=0; clr leaves r_data unchanged. Memory contents are not reset.
- clr has priority over w_en and r_en in the same cycle.
- Write accepted (wr_ok) = w_en & ~full: mem[w_ptr[ADDR_W-1:0]] <= w_data; w_ptr <= w_ptr+1.
- Read accepted (rd_ok) = r_en & ~empty: r_data <= mem[r_ptr[ADDR_W-1:0]]; r_valid=1 next cycle; r_ptr <= r_ptr+1. Read latency is 1 cycle.
- r_valid is 0 in every cycle that does not follow an accepted read. r_data holds its last value when no read is accepted.
- Flags use the registered state at the start of the cycle:
  - Writing when full is rejected even if a read is accepted in the same cycle.
  - Reading when empty is rejected even if a write is accepted in the same cycle.
- count next value:
  - +1 if wr_ok & ~rd_ok
  - -1 if rd_ok & ~wr_ok
  - unchanged if both or neither
- All flags are registered and derived from the next count, so they are valid in the same cycle as count.
- full is also equal to: (w_ptr[ADDR_W] != r_ptr[ADDR_W]) && (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]). The verification bench asserts this equivalence every cycle.
- empty is also equal to: w_ptr == r_ptr.
- Pointers wrap naturally modulo 2**(ADDR_W+1). The address wraps at DEPTH.
- overflow is set on w_en & full. underflow is set on r_en & empty. Both are cleared only by rst or clr.
- Invariant: count == w_ptr - r_ptr (mod 2**(ADDR_W+1)).

Test Plan:
1. Reset, then write 16 words 0x00..0x0F with no reads -> count steps 1..16. almost_empty drops when count goes 2->3. almost_full rises at count=12. full=1 at count=16. overflow=0.
2. From full, pulse w_en with 0xAA -> data is not stored, count stays 16, overflow=1 and remains 1. Then read 16 words -> r_data=0x00..0x0F, each with an r_valid pulse 1 cycle after r_en. Ends with empty=1.
3. From empty, r_en=1 -> r_valid stays 0, count=0, underflow=1. Then w_en and r_en together while empty -> write accepted, read rejected, count=1.
4. With count=5, w_en and r_en held together for 40 cycles with incrementing data -> count stays 5. Pointers wrap past 31 back to 0. Read data is strictly in write order with no gaps.
5. With count=9 and overflow=1, assert clr together with w_en -> next cycle count=0, empty=1, overflow=0, and the write is ignored.
6. Assert rst asynchronously mid-burst at count=7, between clock edges -> all outputs go to their reset values immediately. After release, the first written word is read back first.

Source files
------------

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO with on-board storage, occupancy counter, almost-full/empty
// thresholds and sticky overflow/underflow flags. A synchronous clr flushes it.
module fifo_sync_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   w_ptr,
  output logic [ADDR_W:0]   r_ptr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W:0]   count_next;

  // Acceptance uses the registered flags, so a simultaneous read never
  // rescues a write into a full FIFO (and vice versa for empty).
  always_comb begin
    wr_ok      = w_en & ~full;
    rd_ok      = r_en & ~empty;
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + ONE;
    else if (rd_ok && !wr_ok)
      count_next = count - ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clr)
      mem[w_ptr[ADDR_W-1:0]] <= w_data;
  end

  // Flags are registered from count_next so they line up with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
    end else if (clr) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      if (wr_ok)
        w_ptr <= w_ptr + ONE;
      if (rd_ok) begin
        r_ptr  <= r_ptr + ONE;
        r_data <= mem[r_ptr[ADDR_W-1:0]];
      end
      r_valid      <= rd_ok;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_L);
      almost_full  <= (count_next >= AF_L);
      almost_empty <= (count_next <= AE_L);
      overflow     <= overflow | (w_en & full);
      underflow    <= underflow | (r_en & empty);
    end
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed self-checking bench for fifo_sync_ctrl: fill, overflow, drain,
// underflow, wrap under simultaneous traffic, flush and asynchronous reset.
module tb_fifo_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       w_en;
  logic [7:0] w_data;
  logic       r_en;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic [4:0] w_ptr;
  logic [4:0] r_ptr;

  int vectors    = 0;
  int miscompares = 0;

  fifo_sync_ctrl #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .r_valid(r_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .w_ptr(w_ptr), .r_ptr(r_ptr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pointer/flag relationships that must hold in every cycle.
  always @(negedge clk) begin
    vectors++;
    if (full !== ((w_ptr[4] != r_ptr[4]) && (w_ptr[3:0] == r_ptr[3:0]))) begin
      miscompares++;
      $display("[TB] FAIL full_vs_ptrs: full=%b w_ptr=%0d r_ptr=%0d", full, w_ptr, r_ptr);
    end
    vectors++;
    if (empty !== (w_ptr == r_ptr)) begin
      miscompares++;
      $display("[TB] FAIL empty_vs_ptrs: empty=%b w_ptr=%0d r_ptr=%0d", empty, w_ptr, r_ptr);
    end
    vectors++;
    if (count !== 5'(w_ptr - r_ptr)) begin
      miscompares++;
      $display("[TB] FAIL count_vs_ptrs: count=%0d w_ptr=%0d r_ptr=%0d", count, w_ptr, r_ptr);
    end
  end

  task automatic check_reset_state(input string tag, input logic [7:0] exp_rdata);
    vectors++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, r_valid, w_ptr, r_ptr}
        !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
      miscompares++;
      $display("[TB] FAIL %s state: count=%0d empty=%b ae=%b full=%b af=%b ovf=%b unf=%b rv=%b wp=%0d rp=%0d, required all cleared, empty/ae=1",
               tag, count, empty, almost_empty, full, almost_full, overflow, underflow, r_valid, w_ptr, r_ptr);
    end
    vectors++;
    if (r_data !== exp_rdata) begin
      miscompares++;
      $display("[TB] FAIL %s r_data: got %h required %h", tag, r_data, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = 8'h00;
    #2;
    check_reset_state("reset", 8'h00);
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_state("after_reset", 8'h00);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      w_en = 1'b1; w_data = 8'(i);
      step();
      vectors++;
      if ({count, almost_empty, almost_full, full, overflow} !==
          {5'(i+1), (i+1 <= 2), (i+1 >= 12), (i+1 == 16), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL fill[%0d]: count=%0d ae=%b af=%b full=%b ovf=%b", i, count, almost_empty, almost_full, full, overflow);
      end
    end
    w_en = 1'b0;
  endtask

  task automatic test_overflow_drain();
    w_en = 1'b1; w_data = 8'hAA;
    step();
    w_en = 1'b0;
    vectors++;
    if ({count, full, overflow, w_ptr} !== {5'd16, 1'b1, 1'b1, 5'd16}) begin
      miscompares++;
      $display("[TB] FAIL overflow_write: count=%0d full=%b ovf=%b wp=%0d, required 16 1 1 16", count, full, overflow, w_ptr);
    end
    step();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_sticky: got %b required 1", overflow);
    end
    r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      vectors++;
      if ({r_valid, r_data, count} !== {1'b1, 8'(i), 5'(15-i)}) begin
        miscompares++;
        $display("[TB] FAIL drain[%0d]: rv=%b r_data=%h count=%0d, required 1 %h %0d", i, r_valid, r_data, count, 8'(i), 15-i);
      end
    end
    r_en = 1'b0;
    step();
    vectors++;
    if ({r_valid, empty, overflow, r_data} !== {1'b0, 1'b1, 1'b1, 8'h0F}) begin
      miscompares++;
      $display("[TB] FAIL drain_end: rv=%b empty=%b ovf=%b r_data=%h, required 0 1 1 0f", r_valid, empty, overflow, r_data);
    end
  endtask

  task automatic test_underflow();
    r_en = 1'b1;
    step();
    vectors++;
    if ({r_valid, count, underflow, r_data} !== {1'b0, 5'd0, 1'b1, 8'h0F}) begin
      miscompares++;
      $display("[TB] FAIL underflow_read: rv=%b count=%0d unf=%b r_data=%h, required 0 0 1 0f", r_valid, count, underflow, r_data);
    end
    w_en = 1'b1; w_data = 8'h55;
    step();
    r_en = 1'b0;
    vectors++;
    if ({r_valid, count, empty} !== {1'b0, 5'd1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rw_while_empty: rv=%b count=%0d empty=%b, required 0 1 0", r_valid, count, empty);
    end
    for (int i = 0; i < 4; i++) begin
      w_data = 8'h56 + 8'(i);
      step();
    end
    w_en = 1'b0;
    vectors++;
    if ({count, w_ptr, r_ptr} !== {5'd5, 5'd21, 5'd16}) begin
      miscompares++;
      $display("[TB] FAIL preload5: count=%0d wp=%0d rp=%0d, required 5 21 16", count, w_ptr, r_ptr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    w_en = 1'b1; r_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w_data = 8'h60 + 8'(k);
      step();
      exp = (k < 5) ? 8'h55 + 8'(k) : 8'h60 + 8'(k - 5);
      vectors++;
      if ({r_valid, r_data, count, w_ptr} !== {1'b1, exp, 5'd5, 5'(22 + k)}) begin
        miscompares++;
        $display("[TB] FAIL b2b[%0d]: rv=%b r_data=%h count=%0d wp=%0d, required 1 %h 5 %0d", k, r_valid, r_data, count, w_ptr, exp, (22 + k) % 32);
      end
    end
    w_en = 1'b0; r_en = 1'b0;
    step();
    vectors++;
    if ({r_valid, r_data, count, w_ptr, r_ptr} !== {1'b0, 8'h82, 5'd5, 5'd29, 5'd24}) begin
      miscompares++;
      $display("[TB] FAIL b2b_end: rv=%b r_data=%h count=%0d wp=%0d rp=%0d, required 0 82 5 29 24", r_valid, r_data, count, w_ptr, r_ptr);
    end
  endtask

  task automatic test_clr();
    w_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = 8'h90 + 8'(i);
      step();
    end
    vectors++;
    if ({count, overflow, underflow} !== {5'd9, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL pre_clr: count=%0d ovf=%b unf=%b, required 9 1 1", count, overflow, underflow);
    end
    clr = 1'b1; w_data = 8'hEE;
    step();
    clr = 1'b0; w_en = 1'b0;
    check_reset_state("clr", 8'h82);
    step();
    check_reset_state("post_clr", 8'h82);
  endtask

  task automatic test_async_reset();
    w_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      w_data = 8'hB0 + 8'(i);
      step();
    end
    vectors++;
    if (count !== 5'd7) begin
      miscompares++;
      $display("[TB] FAIL pre_rst: count=%0d required 7", count);
    end
    w_data = 8'hB7;
    #3 rst = 1'b1;
    #1;
    check_reset_state("async_rst", 8'h00);
    w_en = 1'b0;
    #2 rst = 1'b0;
    w_en = 1'b1; w_data = 8'hC3;
    step();
    w_data = 8'hC4;
    step();
    w_en = 1'b0; r_en = 1'b1;
    step();
    vectors++;
    if ({r_valid, r_data} !== {1'b1, 8'hC3}) begin
      miscompares++;
      $display("[TB] FAIL rst_first_read: rv=%b r_data=%h, required 1 c3", r_valid, r_data);
    end
    step();
    r_en = 1'b0;
    vectors++;
    if ({r_valid, r_data, empty} !== {1'b1, 8'hC4, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL rst_second_read: rv=%b r_data=%h empty=%b, required 1 c4 1", r_valid, r_data, empty);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
